// File: rtl/vpu_exec_unit_pipe.sv
// vpu_exec_unit_pipe: multi-lane vector execution unit for element-wise ops and reductions
// Ports: clk/rst; start_i, opcode_i, beat_cnt_i from decoder/controller; busy_o, done_o, err_o status;
// src_valid_i/src_ready_o/src_data_i source beats (A,B,C per lane); res_valid_o/res_ready_i/res_data_o/res_last_o
// element-wise result stream; red_result_o reduction result held until the next start.
module vpu_exec_unit_pipe #(
  parameter int VLANE_CNT     = 8,
  parameter int OPERAND_WIDTH = 16,
  parameter int SRC_CNT       = 3,
  parameter int MAX_BEATS     = 64,
  parameter int BEAT_W        = $clog2(MAX_BEATS + 1),
  parameter int RED_W         = OPERAND_WIDTH + $clog2(VLANE_CNT * MAX_BEATS)
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start_i,
  input  logic [2:0]                                 opcode_i,
  input  logic [BEAT_W-1:0]                          beat_cnt_i,
  output logic                                       busy_o,
  output logic                                       done_o,
  output logic                                       err_o,
  input  logic                                       src_valid_i,
  output logic                                       src_ready_o,
  input  logic [SRC_CNT*VLANE_CNT*OPERAND_WIDTH-1:0] src_data_i,
  output logic                                       res_valid_o,
  input  logic                                       res_ready_i,
  output logic [VLANE_CNT*OPERAND_WIDTH-1:0]         res_data_o,
  output logic                                       res_last_o,
  output logic [RED_W-1:0]                           red_result_o
);
  localparam int OW = OPERAND_WIDTH;
  localparam int RW = VLANE_CNT * OW;
  localparam logic signed [RED_W-1:0] MINV = {{(RED_W-OW+1){1'b1}}, {(OW-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, FIN} state_t;
  state_t state_q;
  logic [2:0] op_q;
  logic [BEAT_W-1:0] bc_q, cnt_q;
  logic res_valid_q, res_last_q, done_q, err_q;
  logic [RW-1:0] res_data_q, res_d;
  logic signed [RED_W-1:0] acc_q, acc_d, red_q, ae;
  logic signed [OW-1:0] a, b, c, r;
  logic red_op, acc_ok, fin_beat, bad_cnt;
  assign red_op   = op_q[2] & op_q[1];
  assign src_ready_o = (state_q == RUN) && (red_op || !res_valid_q || res_ready_i);
  assign acc_ok   = src_valid_i & src_ready_o;
  assign fin_beat = cnt_q == bc_q - BEAT_W'(1);
  assign bad_cnt  = (beat_cnt_i == '0) || (beat_cnt_i > BEAT_W'(MAX_BEATS));
  assign busy_o       = state_q != IDLE;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign res_valid_o  = res_valid_q;
  assign res_data_o   = res_data_q;
  assign res_last_o   = res_last_q;
  assign red_result_o = red_q;
  // Per-lane ALU and reduction fold of all lanes of operand A into the running accumulator
  always_comb begin
    res_d = '0;
    acc_d = acc_q;
    a = '0;
    b = '0;
    c = '0;
    r = '0;
    ae = '0;
    for (int l = 0; l < VLANE_CNT; l++) begin
      a = src_data_i[l*OW +: OW];
      b = src_data_i[(VLANE_CNT+l)*OW +: OW];
      c = src_data_i[(2*VLANE_CNT+l)*OW +: OW];
      r = op_q == 3'd0 ? a + b :
          op_q == 3'd1 ? a - b :
          op_q == 3'd2 ? (a > b ? a : b) :
          op_q == 3'd3 ? (a < b ? a : b) :
          op_q == 3'd4 ? a * b : a * b + c;
      res_d[l*OW +: OW] = r;
      ae = {{(RED_W-OW){a[OW-1]}}, a};
      acc_d = op_q == 3'd6 ? acc_d + ae : (ae > acc_d ? ae : acc_d);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      bc_q        <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      red_q       <= '0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      res_data_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          op_q    <= opcode_i;
          bc_q    <= beat_cnt_i;
          cnt_q   <= '0;
          red_q   <= '0;
          acc_q   <= opcode_i == 3'd7 ? MINV : '0;
          err_q   <= bad_cnt;
          done_q  <= bad_cnt;
          state_q <= bad_cnt ? FIN : RUN;
        end
        RUN: begin
          if (acc_ok) begin
            cnt_q <= cnt_q + BEAT_W'(1);
            acc_q <= acc_d;
          end
          if (!red_op && acc_ok) begin
            res_data_q  <= res_d;
            res_valid_q <= 1'b1;
            res_last_q  <= fin_beat;
          end else if (!red_op && res_ready_i) begin
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
          end
          if (acc_ok && fin_beat) begin
            state_q <= red_op ? FIN : FLUSH;
            done_q  <= red_op;
            if (red_op) red_q <= acc_d;
          end
        end
        FLUSH: if (res_ready_i) begin
          res_valid_q <= 1'b0;
          res_last_q  <= 1'b0;
          done_q      <= 1'b1;
          state_q     <= FIN;
        end
        FIN: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vpu_exec_unit_pipe.sv
// tb_vpu_exec_unit_pipe: directed bench with a queue/integer reference model and literal checks
module tb_vpu_exec_unit_pipe;
  localparam int L = 8, W = 16, BW = 7, RDW = 25, SW = 3 * L * W, RW = L * W;
  logic clk = 0, rst = 1, start_i = 0, src_valid_i = 0, res_ready_i = 1;
  logic [2:0] opcode_i = 0;
  logic [BW-1:0] beat_cnt_i = 0;
  logic [SW-1:0] src_data_i = '0;
  logic busy_o, done_o, err_o, src_ready_o, res_valid_o, res_last_o;
  logic [RW-1:0] res_data_o;
  logic [RDW-1:0] red_result_o;
  int total = 0, bad = 0;
  typedef struct {logic [RW-1:0] d; logic l;} exp_t;
  exp_t q[$];
  int cur_op = 0, cur_cnt = 0, seen = 0;
  bit exp_err = 0;
  longint macc = 0;
  bit [3:0] rr_pat = 4'b1001;
  int rr_len = 0, rr_idx = 0;
  vpu_exec_unit_pipe dut (
    .clk(clk), .rst(rst), .start_i(start_i), .opcode_i(opcode_i), .beat_cnt_i(beat_cnt_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .src_valid_i(src_valid_i),
    .src_ready_o(src_ready_o), .src_data_i(src_data_i), .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i), .res_data_o(res_data_o), .res_last_o(res_last_o),
    .red_result_o(red_result_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", n, act, exp);
    end
  endtask
  function automatic logic [W-1:0] lane(input int op, input int a, input int b, input int c);
    int r;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a > b ? a : b;
      3: r = a < b ? a : b;
      4: r = a * b;
      default: r = a * b + c;
    endcase
    return r[W-1:0];
  endfunction
  function automatic logic [SW-1:0] mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    logic [SW-1:0] d;
    for (int l = 0; l < L; l++) begin
      d[l*W +: W] = a;
      d[(L+l)*W +: W] = b;
      d[(2*L+l)*W +: W] = c;
    end
    return d;
  endfunction
  // Reference model and per-cycle compare, sampled mid-cycle when inputs are stable
  initial forever begin
    @(negedge clk);
    if (rst) q.delete();
    else begin
      if (q.size() == 0) chk("res_idle", res_valid_o, 0);
      else begin
        chk("res_valid", res_valid_o, 1);
        chk("res_data", res_data_o, q[0].d);
        chk("res_last", res_last_o, q[0].l);
        if (res_valid_o && res_ready_i) void'(q.pop_front());
      end
      if (done_o) begin
        chk("done_err", err_o, exp_err);
        chk("drained", q.size(), 0);
        if (cur_op >= 6 && !exp_err) chk("red_model", $signed(red_result_o), macc);
      end
      if (src_valid_i && src_ready_o) begin
        exp_t e;
        for (int l = 0; l < L; l++) begin
          int a, b, c;
          a = $signed(src_data_i[l*W +: W]);
          b = $signed(src_data_i[(L+l)*W +: W]);
          c = $signed(src_data_i[(2*L+l)*W +: W]);
          e.d[l*W +: W] = lane(cur_op, a, b, c);
          if (cur_op == 6) macc += a;
          else if (cur_op == 7 && a > macc) macc = a;
        end
        e.l = seen == cur_cnt - 1;
        seen++;
        if (cur_op < 6) q.push_back(e);
      end
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (rr_len > 0) begin
      res_ready_i = rr_pat[rr_idx];
      rr_idx = (rr_idx + 1) % rr_len;
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic start_op(input int op, input int n);
    start_i = 1;
    opcode_i = op[2:0];
    beat_cnt_i = n[BW-1:0];
    cur_op = op;
    cur_cnt = n;
    seen = 0;
    exp_err = (n == 0) || (n > 64);
    macc = op == 7 ? -32768 : 0;
    tick;
    start_i = 0;
  endtask
  task automatic beat(input logic [SW-1:0] d);
    int g = 0;
    bit ok;
    src_valid_i = 1;
    src_data_i = d;
    do begin
      @(negedge clk);
      ok = src_ready_o;
      tick;
      g++;
    end while (!ok && g < 50);
    if (!ok) chk("beat_timeout", src_ready_o, 1);
    src_valid_i = 0;
  endtask
  task automatic wait_done;
    int g = 0;
    while (!done_o && g < 300) begin
      tick;
      g++;
    end
    chk("done_seen", done_o, 1);
    tick;
  endtask
  initial begin
    logic [SW-1:0] d;
    repeat (3) tick;
    rst = 0;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_srdy", src_ready_o, 0);
    chk("rst_rvalid", res_valid_o, 0);
    chk("rst_rdata", res_data_o, 0);
    chk("rst_red", red_result_o, 0);
    tick;
    d = mk(16'h0000, 16'h0010, 16'h0000);
    for (int l = 0; l < L; l++) d[l*W +: W] = l[W-1:0];
    start_op(0, 2);
    chk("add_busy", busy_o, 1);
    beat(d);
    chk("add_r1", res_data_o, 128'h0017_0016_0015_0014_0013_0012_0011_0010);
    chk("add_l1", res_last_o, 0);
    beat(d);
    chk("add_r2", res_data_o, 128'h0017_0016_0015_0014_0013_0012_0011_0010);
    chk("add_l2", res_last_o, 1);
    tick;
    chk("add_done", done_o, 1);
    tick;
    chk("add_idle", busy_o, 0);
    start_op(1, 1);
    beat(mk(16'h0000, 16'h0001, 16'h0000));
    chk("sub_wrap", res_data_o, {8{16'hFFFF}});
    wait_done;
    start_op(2, 1);
    beat(mk(16'h8000, 16'h7FFF, 16'h0000));
    chk("max", res_data_o, {8{16'h7FFF}});
    wait_done;
    start_op(3, 1);
    beat(mk(16'h8000, 16'h7FFF, 16'h0000));
    chk("min", res_data_o, {8{16'h8000}});
    wait_done;
    start_op(4, 1);
    beat(mk(16'h0003, 16'hFFFF, 16'h0000));
    chk("mul", res_data_o, {8{16'hFFFD}});
    wait_done;
    rr_idx = 0;
    rr_len = 4;
    start_op(5, 5);
    for (int k = 0; k < 5; k++) begin
      logic [W-1:0] cc;
      cc = 16'h0003 + k[W-1:0];
      beat(mk(16'h0100, 16'h0100, cc));
      if (k == 0) chk("mac_r1", res_data_o, {8{16'h0003}});
    end
    wait_done;
    rr_len = 0;
    res_ready_i = 1;
    start_op(6, 64);
    for (int k = 0; k < 64; k++) beat(mk(16'h7FFF, 16'h0000, 16'h0000));
    chk("rsum_done", done_o, 1);
    chk("rsum", red_result_o, 25'd16776704);
    tick;
    chk("rsum_hold", red_result_o, 25'd16776704);
    start_op(7, 2);
    beat(mk(16'h8000, 16'h0000, 16'h0000));
    d = mk(16'h8000, 16'h0000, 16'h0000);
    d[3*W +: W] = 16'hFFFE;
    beat(d);
    chk("rmax", red_result_o, 25'h1FFFFFE);
    wait_done;
    start_op(0, 0);
    chk("err0_done", done_o, 1);
    chk("err0_err", err_o, 1);
    chk("err0_srdy", src_ready_o, 0);
    tick;
    chk("err0_clr", {done_o, err_o}, 0);
    start_op(0, 65);
    chk("err65_err", err_o, 1);
    tick;
    start_op(0, 1);
    start_i = 1;
    opcode_i = 3'd1;
    beat_cnt_i = 7'd5;
    beat(mk(16'h0001, 16'h0002, 16'h0000));
    start_i = 0;
    chk("busy_start_r", res_data_o, {8{16'h0003}});
    chk("busy_start_l", res_last_o, 1);
    wait_done;
    start_op(0, 3);
    beat(mk(16'h0001, 16'h0001, 16'h0000));
    rst = 1;
    tick;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_rv", res_valid_o, 0);
    chk("midrst_rd", res_data_o, 0);
    chk("midrst_srdy", src_ready_o, 0);
    chk("midrst_done", done_o, 0);
    rst = 0;
    repeat (2) tick;
    chk("midrst_nodone", done_o, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
